// File: rtl/spiflash_rd_pkg.sv
// Shared types and constants for the SPI flash read controller.
// Holds the FSM state encoding, flash opcodes and bit-count widths.
package spiflash_rd_pkg;

    typedef enum logic [2:0] {
        WAKE, WAKE_GAP, IDLE, CMD, ADDR, DATA, HOLD, GAP
    } state_t;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_WAKE = 8'hAB;

    localparam int BIT_W = 7;
    localparam int DIV_W = 8;

    localparam logic [BIT_W-1:0] NB_WAKE = 7'd8;
    localparam logic [BIT_W-1:0] NB_READ = 7'd64;
    localparam logic [BIT_W-1:0] NB_WORD = 7'd32;
    localparam logic [BIT_W-1:0] NB_CMD  = 7'd8;
    localparam logic [BIT_W-1:0] NB_HDR  = 7'd32;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spiflash_rd_shifter.sv
// SCK divider plus MSB-first shift-out/shift-in engine for one csb-low burst.
// One setup cycle after start, then 2*CLK_DIV cycles per bit; no backpressure.
module spiflash_rd_shifter
    import spiflash_rd_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [BIT_W-1:0] i_nbits,
    input  logic [31:0]      i_sout,
    input  logic             i_miso,
    output logic             o_sck,
    output logic             o_mosi,
    output logic [31:0]      o_sin,
    output logic [BIT_W-1:0] o_bit_idx,
    output logic             o_rise,
    output logic             o_done
);

    logic             r_busy;
    logic             r_lead;
    logic             r_sck;
    logic [DIV_W-1:0] r_div;
    logic [BIT_W-1:0] r_nbits;
    logic [BIT_W-1:0] r_bit_idx;
    logic [31:0]      r_sout;
    logic [31:0]      r_sin;
    logic             w_phase_end;
    logic             w_fall;

    assign w_phase_end = r_busy && !r_lead && (r_div == DIV_W'(CLK_DIV - 1));
    assign o_rise      = w_phase_end && !r_sck;
    assign w_fall      = w_phase_end && r_sck;
    assign o_done      = w_fall && (r_bit_idx == r_nbits - BIT_W'(1));

    assign o_sck     = r_sck;
    assign o_mosi    = r_sout[31];
    assign o_sin     = r_sin;
    assign o_bit_idx = r_bit_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_lead    <= 1'b0;
            r_sck     <= 1'b0;
            r_div     <= '0;
            r_nbits   <= '0;
            r_bit_idx <= '0;
            r_sout    <= '0;
            r_sin     <= '0;
        end else if (i_start) begin
            // the lead cycle gives io0 a full clk of setup after csb falls
            r_busy    <= 1'b1;
            r_lead    <= 1'b1;
            r_sck     <= 1'b0;
            r_div     <= '0;
            r_bit_idx <= '0;
            r_nbits   <= i_nbits;
            r_sout    <= i_sout;
        end else if (r_busy) begin
            if (r_lead) begin
                r_lead <= 1'b0;
            end else if (w_phase_end) begin
                r_div <= '0;
                r_sck <= !r_sck;
                if (r_sck) begin
                    r_sout    <= {r_sout[30:0], 1'b0};
                    r_bit_idx <= r_bit_idx + BIT_W'(1);
                    if (o_done) r_busy <= 1'b0;
                end else begin
                    r_sin <= {r_sin[30:0], i_miso};
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spiflash_rd_ctrl.sv
// Memory-mapped SPI flash word reader with wake-up and sequential-read continuation.
// Fresh read 128*CLK_DIV+2 cycles, continued read 64*CLK_DIV+2; valid held until the ready pulse.
module spiflash_rd_ctrl
    import spiflash_rd_pkg::*;
#(
    parameter int CLK_DIV  = 1,
    parameter int CSB_IDLE = 4,
    parameter bit CONT_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [23:0] addr,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    state_t           r_state;
    state_t           w_next;
    logic             r_csb;
    logic             r_ready;
    logic [31:0]      r_rdata;
    logic [21:0]      r_cur_addr;
    logic [21:0]      r_nxt_addr;
    logic             r_nxt_vld;
    logic [15:0]      r_gap_cnt;
    logic             w_csb_nxt;
    logic             w_start;
    logic [BIT_W-1:0] w_nbits;
    logic [31:0]      w_sout;
    logic [31:0]      w_sin;
    logic [BIT_W-1:0] w_bit_idx;
    logic             w_rise;
    logic             w_done;
    logic             w_gap_end;
    logic             w_cont;

    spiflash_rd_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_nbits   (w_nbits),
        .i_sout    (w_sout),
        .i_miso    (flash_io1),
        .o_sck     (flash_clk),
        .o_mosi    (flash_io0),
        .o_sin     (w_sin),
        .o_bit_idx (w_bit_idx),
        .o_rise    (w_rise),
        .o_done    (w_done)
    );

    assign w_gap_end = int'(r_gap_cnt) >= CSB_IDLE - 1;
    assign w_cont    = CONT_EN && r_nxt_vld && (addr[23:2] == r_nxt_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAKE;
            r_csb   <= 1'b1;
        end else begin
            r_state <= w_next;
            r_csb   <= w_csb_nxt;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            WAKE:     if (w_done) w_next = WAKE_GAP;
            WAKE_GAP: if (w_gap_end) w_next = IDLE;
            IDLE:     if (valid) w_next = CMD;
            CMD:      if (w_rise && w_bit_idx == NB_CMD) w_next = ADDR;
            ADDR:     if (w_rise && w_bit_idx == NB_HDR) w_next = DATA;
            DATA:     if (w_done) w_next = HOLD;
            // r_ready masks the request that was just answered
            HOLD:     if (valid && !r_ready) w_next = w_cont ? DATA : GAP;
            GAP:      if (w_gap_end) w_next = CMD;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_start   = 1'b0;
        w_nbits   = NB_READ;
        w_sout    = {CMD_READ, addr & 24'hFFFFFC};
        w_csb_nxt = !(w_next inside {WAKE, CMD, ADDR, DATA, HOLD});
        unique case (r_state)
            WAKE: begin
                if (r_csb) begin
                    w_start = 1'b1;
                    w_nbits = NB_WAKE;
                    w_sout  = {CMD_WAKE, 24'h000000};
                end
            end
            IDLE: w_start = valid;
            GAP:  w_start = w_gap_end;
            HOLD: begin
                if (valid && !r_ready && w_cont) begin
                    w_start = 1'b1;
                    w_nbits = NB_WORD;
                    w_sout  = '0;
                end
            end
            default: w_start = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap_cnt  <= '0;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_cur_addr <= '0;
            r_nxt_addr <= '0;
            r_nxt_vld  <= 1'b0;
        end else begin
            r_gap_cnt <= (r_state == WAKE_GAP || r_state == GAP) ? r_gap_cnt + 16'd1 : 16'd0;
            r_ready   <= (r_state == DATA) && w_done;
            if ((r_state == DATA) && w_done) begin
                r_rdata    <= bswap32(w_sin);
                r_nxt_addr <= r_cur_addr + 22'd1;
                r_nxt_vld  <= 1'b1;
            end else if (w_next == GAP) begin
                r_nxt_vld <= 1'b0;
            end
            if (w_start && r_state != WAKE) r_cur_addr <= addr[23:2];
        end
    end

    assign ready     = r_ready & valid;
    assign rdata     = r_rdata;
    assign flash_csb = r_csb;

endmodule

// File: tb/tb_spiflash_rd_ctrl.sv
// Directed bench for spiflash_rd_ctrl against a behavioural read-only SPI flash.
module tb_spiflash_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [23:0] addr = 24'h0;
    logic        ready;
    logic [31:0] rdata;
    logic        flash_csb;
    logic        flash_clk;
    logic        flash_io0;
    logic        flash_io1;

    int n_vec = 0;
    int n_err = 0;

    spiflash_rd_ctrl #(.CLK_DIV(1), .CSB_IDLE(4), .CONT_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .addr      (addr),
        .ready     (ready),
        .rdata     (rdata),
        .flash_csb (flash_csb),
        .flash_clk (flash_clk),
        .flash_io0 (flash_io0),
        .flash_io1 (flash_io1)
    );

    always #5 clk = ~clk;

    // behavioural flash: opcode + 24-bit address, data driven on SCK fall
    logic [7:0]  mem [logic [23:0]];
    int          m_cnt = 0;
    logic [7:0]  m_cmd = 8'h00;
    logic [23:0] m_addr = 24'h0;
    logic        m_io1 = 1'b0;
    int          last_bits = 0;
    logic [7:0]  last_cmd = 8'h00;
    int          n_csb_rise = 0;
    int          n_sck_rise = 0;
    int          n_csb_hi = 0;
    int          bad_csbclk = 0;
    int          bad_io0 = 0;
    int          bad_rdy = 0;
    logic        p_io0 = 1'b0;

    assign flash_io1 = m_io1;

    always @(negedge flash_csb) begin
        m_cnt  = 0;
        m_cmd  = 8'h00;
        m_addr = 24'h0;
    end

    always @(posedge flash_csb) begin
        last_bits = m_cnt;
        last_cmd  = m_cmd;
        m_io1     = 1'b0;
        n_csb_rise++;
    end

    always @(posedge flash_clk) begin
        n_sck_rise++;
        if (!flash_csb) begin
            if (m_cnt < 8) m_cmd = {m_cmd[6:0], flash_io0};
            else if (m_cnt < 32) m_addr = {m_addr[22:0], flash_io0};
            m_cnt++;
        end
    end

    always @(negedge flash_clk) begin
        logic [23:0] ba;
        logic [7:0]  b;
        int          d;
        if (!flash_csb && m_cmd == 8'h03 && m_cnt >= 32) begin
            d  = m_cnt - 32;
            ba = m_addr + 24'(d / 8);
            b  = mem.exists(ba) ? mem[ba] : 8'hFF;
            m_io1 = b[7 - (d % 8)];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (flash_csb) n_csb_hi++;
            if (flash_csb && flash_clk) bad_csbclk++;
            if (flash_io0 !== p_io0 && flash_clk) bad_io0++;
            if (ready && !valid) bad_rdy++;
        end
        p_io0 = flash_io0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input string tag, input logic [23:0] a,
                           input logic [31:0] exp_d, input int exp_lat);
        int lat;
        lat   = 0;
        addr  = a;
        valid = 1'b1;
        while (lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (ready) break;
        end
        chk({tag, ":latency"}, lat, exp_lat);
        chk({tag, ":rdata"}, rdata, exp_d);
        @(posedge clk); #1;
        chk({tag, ":ready_1cyc"}, ready, 1'b0);
        valid = 1'b0;
    endtask

    initial begin
        int cnt;
        int base;
        int base2;

        mem[24'h100000] = 8'h13; mem[24'h100001] = 8'h57;
        mem[24'h100002] = 8'h9B; mem[24'h100003] = 8'hDF;
        mem[24'h100004] = 8'h24; mem[24'h100005] = 8'h68;
        mem[24'h100006] = 8'hAC; mem[24'h100007] = 8'hE0;
        mem[24'h000000] = 8'hA1; mem[24'h000001] = 8'hB2;
        mem[24'h000002] = 8'hC3; mem[24'h000003] = 8'hD4;
        mem[24'h000004] = 8'h01; mem[24'h000005] = 8'h02;
        mem[24'h000006] = 8'h03; mem[24'h000007] = 8'h04;
        mem[24'hFFFFFC] = 8'h5A; mem[24'hFFFFFD] = 8'h6B;
        mem[24'hFFFFFE] = 8'h7C; mem[24'hFFFFFF] = 8'h8D;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst:csb", flash_csb, 1'b1);
        chk("rst:sck", flash_clk, 1'b0);
        chk("rst:io0", flash_io0, 1'b0);
        chk("rst:ready", ready, 1'b0);
        chk("rst:rdata", rdata, 32'h0);

        // wake frame after release
        base = n_csb_rise;
        @(negedge clk) rst = 1'b0;
        cnt = 0;
        while (n_csb_rise == base && cnt < 200) begin @(posedge clk); #1; cnt++; end
        chk("wake:bits", last_bits, 8);
        chk("wake:cmd", last_cmd, 8'hAB);
        repeat (10) @(posedge clk);
        #1;

        // fresh read from IDLE
        do_read("rd100000", 24'h100000, 32'hDF9B5713, 130);
        chk("rd100000:cmd", m_cmd, 8'h03);
        chk("rd100000:addr", m_addr, 24'h100000);

        // sequential continuation
        base = n_csb_rise;
        do_read("rd100004", 24'h100004, 32'hE0AC6824, 66);
        chk("rd100004:csb_rises", n_csb_rise - base, 0);
        chk("rd100004:frame_bits", m_cnt, 96);

        // parked in HOLD: no clocks, csb stays low, rdata held
        base = n_sck_rise;
        repeat (20) @(posedge clk);
        #1;
        chk("hold:sck_rises", n_sck_rise - base, 0);
        chk("hold:csb", flash_csb, 1'b0);
        chk("hold:rdata", rdata, 32'hE0AC6824);

        // non-sequential: csb gap then full frame
        base = n_csb_hi;
        do_read("rd000000", 24'h000000, 32'hD4C3B2A1, 134);
        chk("rd000000:csb_hi", n_csb_hi - base, 4);
        chk("rd000000:cmd", m_cmd, 8'h03);
        chk("rd000000:addr", m_addr, 24'h000000);

        // low address bits ignored
        do_read("rdFFFFFC", 24'hFFFFFF, 32'h8D7C6B5A, 134);
        chk("rdFFFFFC:addr", m_addr, 24'hFFFFFC);

        // continuation across the 24-bit wrap
        base = n_csb_rise;
        do_read("rdwrap", 24'h000000, 32'hD4C3B2A1, 66);
        chk("rdwrap:csb_rises", n_csb_rise - base, 0);

        // reset at the 20th SCK of the address phase
        addr  = 24'h100004;
        valid = 1'b1;
        cnt = 0;
        while (!flash_csb && cnt < 50) begin @(posedge clk); #1; cnt++; end
        cnt = 0;
        while (!(m_cnt == 28 && !flash_csb) && cnt < 200) begin @(posedge clk); #1; cnt++; end
        chk("rstmid:reached", m_cnt, 28);
        rst = 1'b1;
        #1;
        chk("rstmid:csb", flash_csb, 1'b1);
        chk("rstmid:sck", flash_clk, 1'b0);
        chk("rstmid:ready", ready, 1'b0);
        chk("rstmid:rdata", rdata, 32'h0);
        valid = 1'b0;
        repeat (3) @(posedge clk);
        base2 = n_csb_rise;
        @(negedge clk) rst = 1'b0;
        cnt = 0;
        while (n_csb_rise == base2 && cnt < 200) begin @(posedge clk); #1; cnt++; end
        chk("rewake:bits", last_bits, 8);
        chk("rewake:cmd", last_cmd, 8'hAB);
        repeat (10) @(posedge clk);
        #1;
        do_read("rd000004", 24'h000004, 32'h04030201, 130);
        chk("rd000004:addr", m_addr, 24'h000004);

        chk("mon:csb_hi_sck_hi", bad_csbclk, 0);
        chk("mon:io0_while_sck_hi", bad_io0, 0);
        chk("mon:ready_without_valid", bad_rdy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
